// File: rtl/conv_kernel_sched_8x8.sv
// Sequencer for the 8-in/8-out int4 3x3 conv kernel array: loads weights and biases per output group,
// streams ifm windows and tracks kernel latency. Define CONV_SCHED_PERF_EN to add perf counters.
module conv_kernel_sched_8x8 #(
    parameter int KERNEL_LAT = 4,
    parameter int WADDR_W    = 12,
    parameter int NWIN_W     = 16,
    parameter int NGRP_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NWIN_W-1:0]  cfg_num_win,
    input  logic [NGRP_W-1:0]  cfg_num_grp,
    input  logic [WADDR_W-1:0] cfg_wbase,
    output logic               wmem_rd,
    output logic [WADDR_W-1:0] wmem_addr,
    input  logic [35:0]        wmem_rdata,
    output logic               wbank_we,
    output logic [6:0]         wbank_idx,
    output logic               bias_valid,
    input  logic               win_valid,
    output logic               win_ready,
    output logic               kin_valid,
    output logic               ofm_valid,
    output logic               ofm_last,
    output logic               busy,
    output logic               done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_cycle_cnt
`endif
);

    // 64 weight windows followed by 8 bias words per output group
    localparam logic [6:0] LOAD_END = 7'd72;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_BIAS,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [NWIN_W-1:0]    num_win_q, win_cnt, win_nxt;
    logic [NGRP_W-1:0]    num_grp_q, grp_cnt, grp_nxt;
    logic [WADDR_W-1:0]   addr_q;
    logic [6:0]           ld_cnt;
    logic [KERNEL_LAT-1:0] vld_sr, last_sr;
    logic                 kin_last;
    logic                 unused_rdata;

    // Weight data goes straight from memory to the bank; the sequencer never inspects it.
    assign unused_rdata = ^wmem_rdata;

    assign wmem_addr = addr_q;
    assign ofm_valid = vld_sr[KERNEL_LAT-1];
    assign ofm_last  = last_sr[KERNEL_LAT-1];
    assign win_nxt   = win_cnt + NWIN_W'(1);
    assign grp_nxt   = grp_cnt + NGRP_W'(1);

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        wmem_rd    = 1'b0;
        wbank_we   = 1'b0;
        wbank_idx  = 7'd0;
        bias_valid = 1'b0;
        win_ready  = 1'b0;
        kin_valid  = 1'b0;
        kin_last   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (cfg_num_grp == '0) ? S_FIN : S_LOADW;
            end
            S_LOADW: begin
                busy    = 1'b1;
                wmem_rd = (ld_cnt != LOAD_END);
                // Sync-read memory: the write for read k lands one cycle later.
                if (ld_cnt != 7'd0) begin
                    wbank_we  = 1'b1;
                    wbank_idx = ld_cnt - 7'd1;
                end
                if (ld_cnt == LOAD_END) state_d = S_BIAS;
            end
            S_BIAS: begin
                busy       = 1'b1;
                bias_valid = 1'b1;
                state_d    = (num_win_q == '0) ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                win_ready = win_valid;
                kin_valid = win_valid;
                kin_last  = win_valid && (win_nxt == num_win_q);
                if (kin_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Hold off the next weight load until no output of this group is still in flight.
                if (vld_sr == '0) state_d = (grp_nxt == num_grp_q) ? S_FIN : S_LOADW;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            num_win_q <= '0;
            num_grp_q <= '0;
            addr_q    <= '0;
            ld_cnt    <= '0;
            win_cnt   <= '0;
            grp_cnt   <= '0;
            vld_sr    <= '0;
            last_sr   <= '0;
        end else begin
            state_q <= state_d;
            vld_sr  <= (vld_sr << 1) | KERNEL_LAT'(kin_valid);
            last_sr <= (last_sr << 1) | KERNEL_LAT'(kin_last);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_win_q <= cfg_num_win;
                        num_grp_q <= cfg_num_grp;
                        ld_cnt    <= '0;
                        win_cnt   <= '0;
                        grp_cnt   <= '0;
                        if (cfg_num_grp != '0) addr_q <= cfg_wbase;
                    end
                end
                S_LOADW: begin
                    if (wmem_rd) addr_q <= addr_q + WADDR_W'(1);
                    if (ld_cnt == LOAD_END) begin
                        ld_cnt  <= '0;
                        win_cnt <= '0;
                    end else begin
                        ld_cnt <= ld_cnt + 7'd1;
                    end
                end
                S_RUN: begin
                    if (kin_valid) win_cnt <= win_nxt;
                end
                S_DRAIN: begin
                    if (vld_sr == '0) grp_cnt <= grp_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || (state_q == S_IDLE && start)) begin
            perf_stall_cnt <= '0;
            perf_cycle_cnt <= '0;
        end else begin
            if (busy) perf_cycle_cnt <= perf_cycle_cnt + 32'd1;
            if (state_q == S_RUN && !win_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_kernel_sched_8x8.sv
// Scoreboard bench for conv_kernel_sched_8x8: expected reads, bank writes and ofm flags are queued
// when a job is launched and popped by a negedge monitor as the DUT produces them.
module tb_conv_kernel_sched_8x8;

    localparam int KERNEL_LAT = 4;
    localparam int WADDR_W    = 12;
    localparam int NWIN_W     = 16;
    localparam int NGRP_W     = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [NWIN_W-1:0]  cfg_num_win = '0;
    logic [NGRP_W-1:0]  cfg_num_grp = '0;
    logic [WADDR_W-1:0] cfg_wbase = '0;
    logic               wmem_rd;
    logic [WADDR_W-1:0] wmem_addr;
    logic [35:0]        wmem_rdata = '0;
    logic               wbank_we;
    logic [6:0]         wbank_idx;
    logic               bias_valid;
    logic               win_valid = 1'b0;
    logic               win_ready;
    logic               kin_valid;
    logic               ofm_valid;
    logic               ofm_last;
    logic               busy;
    logic               done;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0]        perf_stall_cnt;
    logic [31:0]        perf_cycle_cnt;
`endif

    conv_kernel_sched_8x8 #(
        .KERNEL_LAT(KERNEL_LAT), .WADDR_W(WADDR_W), .NWIN_W(NWIN_W), .NGRP_W(NGRP_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_num_win(cfg_num_win), .cfg_num_grp(cfg_num_grp), .cfg_wbase(cfg_wbase),
        .wmem_rd(wmem_rd), .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
        .wbank_we(wbank_we), .wbank_idx(wbank_idx), .bias_valid(bias_valid),
        .win_valid(win_valid), .win_ready(win_ready), .kin_valid(kin_valid),
        .ofm_valid(ofm_valid), .ofm_last(ofm_last), .busy(busy), .done(done)
`ifdef CONV_SCHED_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_cycle_cnt(perf_cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard and tallies
    int exp_addr[$];
    int exp_idx[$];
    int kin_cyc[$];
    bit exp_last[$];
    int m_nwin, m_win;
    int rd_cnt, bias_cnt, kin_cnt, ofm_cnt, last_cnt, done_cnt;
    int first_kin_cyc, last_kin_cyc, last_ofm_cyc, start_cyc;
    int mon_a, mon_k;
    bit mon_l;

    always @(negedge clk) begin
        if (!rst) begin
            if (wmem_rd) begin
                rd_cnt++;
                n_cmp++;
                if (exp_addr.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_addr: got unexpected read of %h, required no read", wmem_addr);
                end else begin
                    mon_a = exp_addr.pop_front();
                    if (wmem_addr !== WADDR_W'(mon_a)) begin
                        n_err++;
                        $display("FAIL rd_addr: got %h required %h", wmem_addr, WADDR_W'(mon_a));
                    end
                end
            end
            if (wbank_we) begin
                n_cmp++;
                if (exp_idx.size() == 0) begin
                    n_err++;
                    $display("FAIL wbank_idx: got unexpected write idx %0d", wbank_idx);
                end else begin
                    mon_a = exp_idx.pop_front();
                    if (wbank_idx !== 7'(mon_a)) begin
                        n_err++;
                        $display("FAIL wbank_idx: got %0d required %0d", wbank_idx, mon_a);
                    end
                end
                n_cmp++;
                if (kin_cyc.size() != 0) begin
                    n_err++;
                    $display("FAIL we_overlap: got %0d windows in flight, required 0", kin_cyc.size());
                end
            end
            if (bias_valid) bias_cnt++;
            if (ofm_valid) begin
                ofm_cnt++;
                last_ofm_cyc = cyc;
                if (ofm_last) last_cnt++;
                n_cmp++;
                if (kin_cyc.size() == 0) begin
                    n_err++;
                    $display("FAIL ofm_valid: got ofm with no window in flight");
                end else begin
                    mon_k = kin_cyc.pop_front();
                    mon_l = exp_last.pop_front();
                    if ((cyc - mon_k) != KERNEL_LAT || ofm_last !== mon_l) begin
                        n_err++;
                        $display("FAIL ofm_timing: got latency %0d last %b required latency %0d last %b",
                                 cyc - mon_k, ofm_last, KERNEL_LAT, mon_l);
                    end
                end
            end else if (ofm_last) begin
                n_cmp++;
                n_err++;
                $display("FAIL ofm_last: got 1 without ofm_valid, required 0");
            end
            if (kin_valid) begin
                if (kin_cnt == 0) first_kin_cyc = cyc;
                kin_cnt++;
                last_kin_cyc = cyc;
                kin_cyc.push_back(cyc);
                exp_last.push_back(m_win == m_nwin - 1);
                if (m_win == m_nwin - 1) m_win = 0;
                else m_win++;
            end
            if (done) begin
                done_cnt++;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL done_busy: got busy %b with done, required 0", busy);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_stats();
        exp_addr.delete();
        exp_idx.delete();
        kin_cyc.delete();
        exp_last.delete();
        rd_cnt = 0; bias_cnt = 0; kin_cnt = 0; ofm_cnt = 0; last_cnt = 0; done_cnt = 0;
        first_kin_cyc = 0; last_kin_cyc = 0; last_ofm_cyc = 0;
    endtask

    task automatic do_start(input int wbase, input int nwin, input int ngrp);
        clear_stats();
        m_nwin = nwin;
        m_win  = 0;
        for (int g = 0; g < ngrp; g++)
            for (int i = 0; i < 72; i++) begin
                exp_addr.push_back((wbase + 72 * g + i) % 4096);
                exp_idx.push_back(i);
            end
        @(posedge clk); #1;
        cfg_wbase   = wbase[WADDR_W-1:0];
        cfg_num_win = nwin[NWIN_W-1:0];
        cfg_num_grp = ngrp[NGRP_W-1:0];
        start = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        bit seen = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_bias(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bias_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL bias_timeout: got no bias_valid in %0d cycles, required pulse", budget);
        end
    endtask

    task automatic test_reset();
        logic [27:0] o;
        rst = 1'b1;
        win_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = {wmem_rd, wmem_addr, wbank_we, wbank_idx, bias_valid, win_ready, kin_valid,
             ofm_valid, ofm_last, busy, done};
        n_cmp++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", o);
        end
`ifdef CONV_SCHED_PERF_EN
        n_cmp++;
        if (perf_stall_cnt !== 32'd0 || perf_cycle_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_perf: got %0d/%0d required 0/0", perf_stall_cnt, perf_cycle_cnt);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (win_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_outputs: got ready %b busy %b required 0 0", win_ready, busy);
        end
        win_valid = 1'b0;
    endtask

    task automatic test_single_group();
        int dcyc;
        win_valid = 1'b1;
        do_start(12'h010, 4, 1);
        wait_done(1000, dcyc);
        n_cmp++; if (dcyc - start_cyc !== 84) begin n_err++; $display("FAIL t1_done_cycle: got %0d required 84", dcyc - start_cyc); end
        n_cmp++; if (rd_cnt !== 72 || exp_addr.size() != 0) begin n_err++; $display("FAIL t1_reads: got %0d left %0d required 72 left 0", rd_cnt, exp_addr.size()); end
        n_cmp++; if (exp_idx.size() != 0) begin n_err++; $display("FAIL t1_writes: got %0d unwritten required 0", exp_idx.size()); end
        n_cmp++; if (bias_cnt !== 1) begin n_err++; $display("FAIL t1_bias: got %0d required 1", bias_cnt); end
        n_cmp++; if (kin_cnt !== 4) begin n_err++; $display("FAIL t1_kin: got %0d required 4", kin_cnt); end
        n_cmp++; if (last_kin_cyc - first_kin_cyc !== 3) begin n_err++; $display("FAIL t1_kin_span: got %0d required 3", last_kin_cyc - first_kin_cyc); end
        n_cmp++; if (ofm_cnt !== 4 || last_cnt !== 1) begin n_err++; $display("FAIL t1_ofm: got %0d/%0d required 4/1", ofm_cnt, last_cnt); end
        n_cmp++; if (dcyc - last_ofm_cyc !== 2) begin n_err++; $display("FAIL t1_drain: got %0d required 2", dcyc - last_ofm_cyc); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL t1_done_cnt: got %0d required 1", done_cnt); end
        win_valid = 1'b0;
    endtask

    task automatic test_multi_group();
        int dcyc;
        win_valid = 1'b1;
        do_start(12'h000, 2, 3);
        wait_done(2000, dcyc);
        n_cmp++; if (rd_cnt !== 216 || exp_addr.size() != 0) begin n_err++; $display("FAIL t2_reads: got %0d left %0d required 216 left 0", rd_cnt, exp_addr.size()); end
        n_cmp++; if (bias_cnt !== 3) begin n_err++; $display("FAIL t2_bias: got %0d required 3", bias_cnt); end
        n_cmp++; if (ofm_cnt !== 6 || last_cnt !== 3) begin n_err++; $display("FAIL t2_ofm: got %0d/%0d required 6/3", ofm_cnt, last_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL t2_done_cnt: got %0d required 1", done_cnt); end
        win_valid = 1'b0;
    endtask

    task automatic test_win_gaps();
        int dcyc;
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        win_valid = 1'b0;
        do_start(12'h040, 3, 1);
        wait_bias(200);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            win_valid = pat[k];
            @(negedge clk);
            n_cmp++;
            if (win_ready !== pat[k]) begin
                n_err++;
                $display("FAIL t3_ready[%0d]: got %b required %b", k, win_ready, pat[k]);
            end
        end
        @(posedge clk); #1;
        win_valid = 1'b0;
        wait_done(1000, dcyc);
        n_cmp++; if (kin_cnt !== 3 || last_cnt !== 1) begin n_err++; $display("FAIL t3_handshakes: got %0d/%0d required 3/1", kin_cnt, last_cnt); end
`ifdef CONV_SCHED_PERF_EN
        n_cmp++; if (perf_stall_cnt !== 32'd2) begin n_err++; $display("FAIL t3_stall: got %0d required 2", perf_stall_cnt); end
        n_cmp++; if (perf_cycle_cnt !== 32'd84) begin n_err++; $display("FAIL t3_cycles: got %0d required 84", perf_cycle_cnt); end
`endif
    endtask

    task automatic test_zero_cfg();
        int dcyc;
        win_valid = 1'b1;
        do_start(12'h123, 5, 0);
        wait_done(50, dcyc);
        n_cmp++; if (dcyc - start_cyc !== 1) begin n_err++; $display("FAIL t4_grp0_done: got %0d required 1", dcyc - start_cyc); end
        n_cmp++; if (rd_cnt !== 0 || done_cnt !== 1) begin n_err++; $display("FAIL t4_grp0_activity: got rd %0d done %0d required 0 1", rd_cnt, done_cnt); end
        do_start(12'h200, 0, 1);
        wait_done(500, dcyc);
        n_cmp++; if (rd_cnt !== 72 || exp_addr.size() != 0) begin n_err++; $display("FAIL t4_win0_reads: got %0d required 72", rd_cnt); end
        n_cmp++; if (bias_cnt !== 1 || kin_cnt !== 0) begin n_err++; $display("FAIL t4_win0_run: got bias %0d kin %0d required 1 0", bias_cnt, kin_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL t4_win0_done: got %0d required 1", done_cnt); end
        win_valid = 1'b0;
    endtask

    task automatic test_abort_reset();
        int dcyc;
        logic [27:0] o;
        win_valid = 1'b0;
        do_start(12'h080, 5, 1);
        wait_bias(200);
        @(posedge clk); #1; win_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; win_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (kin_cnt !== 2) begin n_err++; $display("FAIL t5_pre_kin: got %0d required 2", kin_cnt); end
        @(posedge clk); #1; rst = 1'b0; win_valid = 1'b1;
        @(negedge clk);
        o = {wmem_rd, wmem_addr, wbank_we, wbank_idx, bias_valid, win_ready, kin_valid,
             ofm_valid, ofm_last, busy, done};
        n_cmp++; if (o !== '0) begin n_err++; $display("FAIL t5_abort_outputs: got %h required 0", o); end
        clear_stats();
        repeat (8) @(negedge clk);
        n_cmp++; if (done_cnt !== 0 || ofm_cnt !== 0) begin n_err++; $display("FAIL t5_after_abort: got done %0d ofm %0d required 0 0", done_cnt, ofm_cnt); end
        do_start(12'h100, 3, 1);
        wait_done(1000, dcyc);
        n_cmp++; if (rd_cnt !== 72 || exp_addr.size() != 0) begin n_err++; $display("FAIL t5_rerun_reads: got %0d required 72", rd_cnt); end
        n_cmp++; if (kin_cnt !== 3 || last_cnt !== 1 || done_cnt !== 1) begin n_err++; $display("FAIL t5_rerun: got kin %0d last %0d done %0d required 3 1 1", kin_cnt, last_cnt, done_cnt); end
        win_valid = 1'b0;
    endtask

    task automatic test_start_while_busy();
        int dcyc;
        win_valid = 1'b1;
        do_start(12'h020, 2, 1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; cfg_wbase = 12'h300; cfg_num_grp = 6'd2; cfg_num_win = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1000, dcyc);
        n_cmp++; if (rd_cnt !== 72 || exp_addr.size() != 0) begin n_err++; $display("FAIL t6_reads: got %0d required 72", rd_cnt); end
        n_cmp++; if (kin_cnt !== 2 || last_cnt !== 1) begin n_err++; $display("FAIL t6_windows: got %0d/%0d required 2/1", kin_cnt, last_cnt); end
        n_cmp++; if (dcyc - start_cyc !== 82) begin n_err++; $display("FAIL t6_done_cycle: got %0d required 82", dcyc - start_cyc); end
        repeat (10) @(negedge clk);
        n_cmp++; if (done_cnt !== 1 || rd_cnt !== 72) begin n_err++; $display("FAIL t6_no_restart: got done %0d rd %0d required 1 72", done_cnt, rd_cnt); end
        win_valid = 1'b0;
    endtask

    initial begin
        clear_stats();
        m_nwin = 0;
        m_win  = 0;
        test_reset();
        test_single_group();
        test_multi_group();
        test_win_gaps();
        test_zero_cfg();
        test_abort_reset();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/conv_kernel_sched_8x8.md
Name: conv_kernel_sched_8x8

Overview:
- Sequencer for the 8-in/8-out int4 3x3 conv kernel array (four 2-filter sub-kernels). For each output-channel group, it loads 64 weight windows and 8 biases from weight memory into the kernel's weight register bank, then streams input windows into the kernel.
- Tracks the kernel's fixed pipeline latency to flag valid outputs. Drains the pipeline before reloading weights.
- Sits between the layer controller (start/done), the ifm window generator (valid/ready) and the weight ROM/BRAM.

Parameters:
- KERNEL_LAT, 4, kernel input-to-ofm latency in clk cycles (kernel is unstallable)
- WADDR_W, 12, weight memory address width
- NWIN_W, 16, window-count width
- NGRP_W, 6, output-group-count width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_num_win  in  NWIN_W  windows per group; 0 means skip RUN
- cfg_num_grp  in  NGRP_W  output groups; 0 means immediate done
- cfg_wbase  in  WADDR_W  weight memory base address
- wmem_rd  out  1  weight memory read enable (sync read, data valid next cycle)
- wmem_addr  out  WADDR_W  weight memory read address
- wmem_rdata  in  36  weight word; bias words use bits [11:0]
- wbank_we  out  1  weight/bias bank write strobe
- wbank_idx  out  7  0..63 = weight window {oc[2:0],ic[2:0]}; 64..71 = bias_0..7
- bias_valid  out  1  one-cycle pulse to kernel after the bias_7 write
- win_valid  in  1  ifm window available
- win_ready  out  1  window consumed this cycle
- kin_valid  out  1  window presented to kernel this cycle
- ofm_valid  out  1  kernel ofm_stream_ch0..7 valid this cycle
- ofm_last  out  1  with ofm_valid: last window of current group
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: all outputs are 0; state is IDLE; counters and address are cleared; the latency shift register is cleared. A reset asserted mid-operation aborts the job immediately, and no done pulse is issued.
- States: IDLE -> LOADW -> BIAS -> RUN -> DRAIN -> (LOADW | FIN) -> IDLE.
- IDLE: on start, latch the cfg_* fields and set busy=1.
  - cfg_num_grp==0: go to FIN.
  - Otherwise: set wmem_addr=cfg_wbase and go to LOADW.
- LOADW: issue 72 consecutive reads, one per cycle, with addr incrementing.
  - wbank_we/wbank_idx trail wmem_rd by 1 cycle. idx 0..71 are in read order.
  - LOADW lasts 73 cycles, counting the trailing write.
  - The address keeps incrementing across groups; group g uses words cfg_wbase+72g .. cfg_wbase+72g+71.
- BIAS: one cycle with bias_valid=1, then go to RUN.
- RUN: win_ready = win_valid. Each handshake sets kin_valid=1 that cycle and increments the window counter.
  - Leave RUN on the cycle of the cfg_num_win-th handshake; that window still enters the kernel.
  - cfg_num_win==0: go straight to DRAIN.
- Valid pipeline: kin_valid is delayed KERNEL_LAT cycles through a shift register to form ofm_valid. The last-window flag travels alongside to form ofm_last.
- DRAIN: wait until the shift register is empty, so there is no overlap of old weights with new outputs.
  - Then increment the group counter; if it equals cfg_num_grp go to FIN, else go to LOADW.
- FIN: done=1 for 1 cycle, busy=0 in the same cycle, then go to IDLE.
- Outside RUN, win_ready=0. start is ignored while busy.
- Weight-bank writes never occur while the shift register is non-empty.

Optional Feature:
- CONV_SCHED_PERF_EN: adds output perf_stall_cnt[31:0], which counts RUN cycles with win_valid=0, and output perf_cycle_cnt[31:0], which counts busy cycles.
  - Both are cleared on rst and on start accept, and hold their value after done.
- Without the macro: the ports and counters are absent.

Test Plan:
- 1 group, 4 windows, win_valid held high, wbase=0x010:
  - reads 0x010..0x057;
  - wbank_idx 0..71;
  - bias_valid exactly once;
  - 4 kin_valid in consecutive cycles;
  - ofm_valid KERNEL_LAT cycles later, with ofm_last on the 4th;
  - done 1 cycle after drain.
- 3 groups, 2 windows each:
  - reads are contiguous 0x000..0x0D7;
  - no wbank_we while ofm_valid is pending;
  - 6 ofm_valid, 3 ofm_last, 1 done.
- win_valid toggling 1,0,0,1,1 with cfg_num_win=3: exactly 3 handshakes; win_ready=0 in the idle-gap cycles; with PERF_EN, perf_stall_cnt=2.
- cfg_num_grp=0: done 1 cycle after start, no wmem_rd. cfg_num_win=0, grp=1: weights load, bias_valid pulses, no kin_valid, done.
- rst asserted during RUN after 2 of 5 windows: next cycle all outputs are 0 and state is IDLE; a new start runs a full job correctly.
- start pulsed while busy: ignored; cfg changes mid-job have no effect.
